// File: rtl/apb_pkg.sv
// Shared types and constants for the APB3 slave memory and its violation checker.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   // Bit positions inside viol_status / per-transfer flags
   localparam int unsigned VIOL_CTRL  = 0;
   localparam int unsigned VIOL_PEN   = 1;
   localparam int unsigned VIOL_ADDR  = 2;
   localparam int unsigned VIOL_ABORT = 3;

   localparam int unsigned VIOL_W = 4;
   localparam int unsigned WAIT_W = 4;
   localparam int unsigned CNT_W  = 8;

   // Field order places ctrl_change at bit 0 to line up with VIOL_* indices
   typedef struct packed {
      logic abort;
      logic addr_range;
      logic penable_early;
      logic ctrl_change;
   } viol_flags_t;

   // Increment that sticks at all-ones
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/apb_viol_checker.sv
// Per-transfer APB protocol violation tracking: accumulates flags across the
// wait states of one transfer and exposes them merged with this cycle's checks.
module apb_viol_checker
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 64
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  apb_state_e        state_i,
   input  logic              psel_i,
   input  logic              penable_i,
   input  logic              pwrite_i,
   input  logic [ADDR_W-1:0] paddr_i,
   input  logic [DATA_W-1:0] pwdata_i,
   input  logic              cap_write_i,
   input  logic [ADDR_W-1:0] cap_addr_i,
   input  logic [DATA_W-1:0] cap_wdata_i,
   input  logic              pready_i,
   output viol_flags_t       flags_c_o
);

   logic [VIOL_W-1:0] flags_q, flags_d;
   logic [VIOL_W-1:0] now_c;
   logic              setup_entry_c;

   // This cycle's checks plus the next value of the accumulated flags
   always_comb begin
      now_c         = '0;
      flags_d       = flags_q;
      setup_entry_c = ((state_i == IDLE) && psel_i) ||
                      ((state_i == ACCESS) && pready_i && psel_i);

      now_c[VIOL_ADDR] = (32'(cap_addr_i) >= DEPTH);
      if (state_i == ACCESS) begin
         now_c[VIOL_CTRL]  = (paddr_i != cap_addr_i) ||
                             (pwrite_i != cap_write_i) ||
                             (cap_write_i && (pwdata_i != cap_wdata_i)) ||
                             !penable_i;
         now_c[VIOL_ABORT] = !psel_i && !pready_i;
      end

      if (setup_entry_c) begin
         // New transfer: only the early-PENABLE observation carries in
         flags_d           = '0;
         flags_d[VIOL_PEN] = penable_i;
      end else if (state_i == ACCESS) begin
         flags_d = flags_q | now_c;
      end
   end

   // Accumulated flag register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         flags_q <= '0;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign flags_c_o = viol_flags_t'(flags_q | now_c);

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 slave backed by a register-file memory, with configurable wait states,
// protocol violation detection, PSLVERR responses and sticky violation status.
module apb_slave_mem
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [ADDR_W-1:0] PADDR,
   input  logic [DATA_W-1:0] PWDATA,
   output logic              PREADY,
   output logic [DATA_W-1:0] PRDATA,
   output logic              PSLVERR,
   output logic [3:0]        viol_status,
   output logic [7:0]        viol_cnt
);

   localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   apb_state_e        state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              cap_write_q, cap_write_d;
   logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
   logic [DATA_W-1:0] cap_wdata_q, cap_wdata_d;
   logic [VIOL_W-1:0] viol_status_q, viol_status_d;
   logic [CNT_W-1:0]  viol_cnt_q, viol_cnt_d;
   logic [DATA_W-1:0] mem_q [DEPTH];

   viol_flags_t       flags_c;
   logic [VIOL_W-1:0] flags_vec_c;
   logic              pready_c;
   logic              err_c;
   logic              mem_we_c;
   logic [MEM_AW-1:0] mem_idx_c;

   apb_viol_checker #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_viol_checker (
      .clk_i       (PCLK),
      .rst_i       (PRESET),
      .state_i     (state_q),
      .psel_i      (PSEL),
      .penable_i   (PENABLE),
      .pwrite_i    (PWRITE),
      .paddr_i     (PADDR),
      .pwdata_i    (PWDATA),
      .cap_write_i (cap_write_q),
      .cap_addr_i  (cap_addr_q),
      .cap_wdata_i (cap_wdata_q),
      .pready_i    (pready_c),
      .flags_c_o   (flags_c)
   );

   // Completion, error and memory access decode; all quiet while in reset
   assign pready_c    = !PRESET && (state_q == ACCESS) && (wait_q == WAIT_W'(WAIT_STATES));
   assign flags_vec_c = flags_c;
   assign err_c       = flags_c.ctrl_change | flags_c.penable_early | flags_c.addr_range;
   assign mem_idx_c   = cap_addr_q[MEM_AW-1:0];
   assign mem_we_c    = pready_c && cap_write_q && !err_c;

   assign PREADY      = pready_c;
   assign PSLVERR     = pready_c && err_c;
   assign PRDATA      = (pready_c && !cap_write_q && !err_c) ? mem_q[mem_idx_c] : '0;
   assign viol_status = viol_status_q;
   assign viol_cnt    = viol_cnt_q;

   // Next-state, capture and status logic
   always_comb begin
      state_d       = state_q;
      wait_d        = wait_q;
      cap_write_d   = cap_write_q;
      cap_addr_d    = cap_addr_q;
      cap_wdata_d   = cap_wdata_q;
      viol_status_d = viol_status_q;
      viol_cnt_d    = viol_cnt_q;

      case (state_q)
         IDLE: begin
            wait_d = '0;
            if (PSEL) begin
               state_d     = SETUP;
               cap_write_d = PWRITE;
               cap_addr_d  = PADDR;
               cap_wdata_d = PWDATA;
            end
         end

         SETUP: begin
            state_d = ACCESS;
            wait_d  = '0;
         end

         ACCESS: begin
            if (pready_c) begin
               viol_status_d = viol_status_q | flags_vec_c;
               if (err_c) begin
                  viol_cnt_d = sat_inc(viol_cnt_q);
               end
               wait_d = '0;
               if (PSEL) begin
                  state_d     = SETUP;
                  cap_write_d = PWRITE;
                  cap_addr_d  = PADDR;
                  cap_wdata_d = PWDATA;
               end else begin
                  state_d = IDLE;
               end
            end else if (!PSEL) begin
               // Master abandoned the transfer before it completed
               state_d       = IDLE;
               wait_d        = '0;
               viol_status_d = viol_status_q | flags_vec_c;
               viol_cnt_d    = sat_inc(viol_cnt_q);
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
            wait_d  = '0;
         end
      endcase
   end

   // Control and status registers
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q       <= IDLE;
         wait_q        <= '0;
         cap_write_q   <= 1'b0;
         cap_addr_q    <= '0;
         cap_wdata_q   <= '0;
         viol_status_q <= '0;
         viol_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         wait_q        <= wait_d;
         cap_write_q   <= cap_write_d;
         cap_addr_q    <= cap_addr_d;
         cap_wdata_q   <= cap_wdata_d;
         viol_status_q <= viol_status_d;
         viol_cnt_q    <= viol_cnt_d;
      end
   end

   // Register-file memory, cleared on reset, written only by error-free writes
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (mem_we_c) begin
         mem_q[mem_idx_c] <= cap_wdata_q;
      end
   end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Self-checking bench for apb_slave_mem: three instances (0, 3 and 2 wait
// states) share the bus except PSEL; a vector table drives transfers and a
// scoreboard queue holds the expected completion of each one.
module tb_apb_slave_mem;

   localparam int K_NORM  = 0;
   localparam int K_EARLY = 1;  // PENABLE high together with PSEL
   localparam int K_WFLIP = 2;  // PWRITE inverted in ACCESS
   localparam int K_ADDR  = 3;  // PADDR changed in ACCESS
   localparam int K_DATA  = 4;  // PWDATA changed in ACCESS
   localparam int K_PEN0  = 5;  // PENABLE low in first ACCESS cycle
   localparam int K_ABORT = 6;  // PSEL dropped in first ACCESS cycle

   typedef struct {
      int          dut;
      bit          wr;
      logic [7:0]  addr;
      logic [31:0] wdata;
      int          kind;
      logic        exp_err;
   } vec_t;

   typedef struct {
      int          cycles;
      logic        slverr;
      bit          is_rd;
      logic [31:0] rdata;
   } exp_t;

   logic        clk;
   logic        preset;
   logic        psel [3];
   logic        penable;
   logic        pwrite;
   logic [7:0]  paddr;
   logic [31:0] pwdata;
   logic        pready [3];
   logic        pslverr [3];
   logic [31:0] prdata [3];
   logic [3:0]  vstat [3];
   logic [7:0]  vcnt [3];

   int          ws_of [3];
   logic [31:0] mdl_mem [3][64];
   logic [3:0]  mdl_status [3];
   logic [7:0]  mdl_cnt [3];
   exp_t        sb_q [$];
   vec_t        vec_a [$];
   vec_t        vec_b [$];
   int          n_cmp;
   int          n_bad;

   apb_slave_mem #(.ADDR_W(8), .DATA_W(32), .DEPTH(64), .WAIT_STATES(0)) u_ws0 (
      .PCLK(clk), .PRESET(preset), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready[0]), .PRDATA(prdata[0]),
      .PSLVERR(pslverr[0]), .viol_status(vstat[0]), .viol_cnt(vcnt[0]));

   apb_slave_mem #(.ADDR_W(8), .DATA_W(32), .DEPTH(64), .WAIT_STATES(3)) u_ws3 (
      .PCLK(clk), .PRESET(preset), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready[1]), .PRDATA(prdata[1]),
      .PSLVERR(pslverr[1]), .viol_status(vstat[1]), .viol_cnt(vcnt[1]));

   apb_slave_mem #(.ADDR_W(8), .DATA_W(32), .DEPTH(64), .WAIT_STATES(2)) u_ws2 (
      .PCLK(clk), .PRESET(preset), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready[2]), .PRDATA(prdata[2]),
      .PSLVERR(pslverr[2]), .viol_status(vstat[2]), .viol_cnt(vcnt[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         mdl_status[d] = '0;
         mdl_cnt[d]    = '0;
         for (int a = 0; a < 64; a++) mdl_mem[d][a] = '0;
      end
   endtask

   function automatic logic [7:0] sat8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   task automatic check_status(input int d);
      check($sformatf("viol_status[%0d]", d), 32'(vstat[d]), 32'(mdl_status[d]));
      check($sformatf("viol_cnt[%0d]", d), 32'(vcnt[d]), 32'(mdl_cnt[d]));
   endtask

   // One transfer on instance d, starting just after a rising edge with the DUT idle
   task automatic xfer(input vec_t v);
      exp_t       e;
      bit         ctrl, pen, rng, ab, done;
      logic [3:0] fl;
      int         cyc;
      int         d;
      d    = v.dut;
      ctrl = (v.kind == K_WFLIP) || (v.kind == K_ADDR) || (v.kind == K_PEN0) ||
             ((v.kind == K_DATA) && v.wr);
      pen  = (v.kind == K_EARLY);
      rng  = (v.addr >= 8'd64);
      ab   = (v.kind == K_ABORT);
      fl   = {ab, rng, pen, ctrl};

      if (ab) begin
         mdl_status[d] = mdl_status[d] | fl;
         mdl_cnt[d]    = sat8(mdl_cnt[d]);
      end else begin
         e.cycles = ws_of[d] + 2;
         e.slverr = v.exp_err;
         e.is_rd  = !v.wr;
         e.rdata  = (!v.wr && !v.exp_err) ? mdl_mem[d][v.addr[5:0]] : 32'h0;
         if (v.wr && !v.exp_err) mdl_mem[d][v.addr[5:0]] = v.wdata;
         if (v.exp_err) mdl_cnt[d] = sat8(mdl_cnt[d]);
         mdl_status[d] = mdl_status[d] | fl;
         sb_q.push_back(e);
      end

      psel[d] = 1'b1;
      penable = pen;
      pwrite  = v.wr;
      paddr   = v.addr;
      pwdata  = v.wdata;
      @(posedge clk); #1;
      penable = 1'b1;
      @(negedge clk);
      check("setup_pready", 32'(pready[d]), 32'h0);
      @(posedge clk); #1;
      case (v.kind)
         K_WFLIP: pwrite  = ~v.wr;
         K_ADDR:  paddr   = v.addr ^ 8'h01;
         K_DATA:  pwdata  = ~v.wdata;
         K_PEN0:  penable = 1'b0;
         K_ABORT: psel[d] = 1'b0;
         default: ;
      endcase
      cyc  = 2;
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (ab) begin
            check("abort_pready", 32'(pready[d]), 32'h0);
            done = 1'b1;
         end else if (pready[d] === 1'b1) begin
            if (sb_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL scoreboard: PREADY with empty queue");
            end else begin
               e = sb_q.pop_front();
               check("cycles", 32'(cyc), 32'(e.cycles));
               check("pslverr", 32'(pslverr[d]), 32'(e.slverr));
               if (e.is_rd) check("prdata", prdata[d], e.rdata);
            end
            psel[d] = 1'b0;
            done = 1'b1;
         end else begin
            @(posedge clk); #1;
            if (v.kind == K_PEN0) penable = 1'b1;
            cyc++;
         end
      end
      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL timeout: no PREADY on dut %0d, got 0 expected 1", d);
         if (sb_q.size() != 0) e = sb_q.pop_front();
         psel[d] = 1'b0;
      end
      @(posedge clk); #1;
      penable = 1'b0;
      pwrite  = 1'b0;
      check_status(d);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      ws_of[0] = 0; ws_of[1] = 3; ws_of[2] = 2;
      for (int d = 0; d < 3; d++) psel[d] = 1'b0;
      penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      preset  = 1'b1;
      model_reset();

      //            dut wr addr    wdata          kind     err
      vec_a.push_back('{0, 1, 8'd5,   32'hA5A5_0001, K_NORM,  1'b0});
      vec_a.push_back('{0, 0, 8'd5,   32'h0,         K_NORM,  1'b0});
      vec_a.push_back('{1, 1, 8'd5,   32'hA5A5_0001, K_NORM,  1'b0});
      vec_a.push_back('{1, 0, 8'd5,   32'h0,         K_NORM,  1'b0});
      vec_a.push_back('{0, 1, 8'd7,   32'h0000_1234, K_WFLIP, 1'b1});
      vec_a.push_back('{0, 0, 8'd7,   32'h0,         K_NORM,  1'b0});
      vec_a.push_back('{0, 1, 8'd64,  32'hDEAD_BEEF, K_NORM,  1'b1});
      vec_a.push_back('{0, 0, 8'd63,  32'h0,         K_NORM,  1'b0});
      vec_a.push_back('{2, 1, 8'd3,   32'h3333_3333, K_ABORT, 1'b0});
      vec_a.push_back('{2, 0, 8'd3,   32'h0,         K_NORM,  1'b0});
      vec_a.push_back('{0, 0, 8'd5,   32'h0,         K_EARLY, 1'b1});
      vec_a.push_back('{2, 1, 8'd10,  32'h0000_CAFE, K_DATA,  1'b1});
      vec_a.push_back('{2, 0, 8'd10,  32'h0,         K_DATA,  1'b0});
      vec_a.push_back('{1, 1, 8'd9,   32'h0000_0099, K_ADDR,  1'b1});
      vec_a.push_back('{1, 1, 8'd9,   32'h0000_0077, K_PEN0,  1'b1});
      vec_a.push_back('{1, 0, 8'd9,   32'h0,         K_NORM,  1'b0});
      vec_a.push_back('{1, 1, 8'd63,  32'h0000_6363, K_NORM,  1'b0});
      vec_a.push_back('{1, 0, 8'd63,  32'h0,         K_NORM,  1'b0});
      vec_a.push_back('{0, 1, 8'd255, 32'h0000_0001, K_NORM,  1'b1});
      vec_a.push_back('{2, 1, 8'd3,   32'h0000_0003, K_NORM,  1'b0});
      vec_a.push_back('{2, 0, 8'd3,   32'h0,         K_NORM,  1'b0});

      vec_b.push_back('{1, 0, 8'd20,  32'h0,         K_NORM,  1'b0});
      vec_b.push_back('{0, 0, 8'd5,   32'h0,         K_NORM,  1'b0});
      vec_b.push_back('{1, 1, 8'd20,  32'h0000_0055, K_NORM,  1'b0});
      vec_b.push_back('{1, 0, 8'd20,  32'h0,         K_NORM,  1'b0});

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) check("reset_pready", 32'(pready[d]), 32'h0);
      @(posedge clk); #1;
      preset = 1'b0;
      for (int d = 0; d < 3; d++) check_status(d);

      foreach (vec_a[i]) xfer(vec_a[i]);

      // Reset in the completion cycle of a 3-wait-state write to addr 20
      psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd20; pwdata = 32'h55;
      @(posedge clk); #1;
      penable = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      preset = 1'b1;
      @(negedge clk);
      check("rst_pready", 32'(pready[1]), 32'h0);
      check("rst_pslverr", 32'(pslverr[1]), 32'h0);
      check("rst_prdata", prdata[1], 32'h0);
      @(posedge clk); #1;
      preset = 1'b0; psel[1] = 1'b0; penable = 1'b0; pwrite = 1'b0;
      model_reset();
      for (int d = 0; d < 3; d++) check_status(d);

      foreach (vec_b[i]) xfer(vec_b[i]);

      // Saturation of the violation counter
      for (int i = 0; i < 260; i++) xfer('{0, 0, 8'd0, 32'h0, K_EARLY, 1'b1});
      check("cnt_saturated", 32'(vcnt[0]), 32'd255);

      if (sb_q.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL scoreboard_drain: %0d left, expected 0", sb_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- Synthesizable APB3 slave with an internal register-file memory; the DUT that the APB environment drives and that the violation tests target.
- Completes legal read/write transfers with a configurable number of wait states.
- Detects protocol violations, including PWRITE/PADDR/PWDATA changing between SETUP and ACCESS, early PENABLE, aborts and out-of-range addresses.
- Answers violations with PSLVERR and records them in sticky status/counter outputs that the scoreboard can cross-check.

Parameters:
- ADDR_W, 8, PADDR width.
- DATA_W, 32, PWDATA/PRDATA width.
- DEPTH, 64, number of words; legal PADDR range is 0..DEPTH-1 (word addressing).
- WAIT_STATES, 0, PREADY-low cycles inserted in each ACCESS phase (0..15).

Ports:
- PCLK  in  1  clock, all logic on rising edge.
- PRESET  in  1  synchronous, active-high reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1=write, 0=read.
- PADDR  in  ADDR_W  word address.
- PWDATA  in  DATA_W  write data.
- PREADY  out  1  transfer completes this cycle.
- PRDATA  out  DATA_W  read data, valid only when PREADY=1 and PWRITE=0.
- PSLVERR  out  1  error response, valid only when PREADY=1.
- viol_status  out  4  sticky flags: [0] ctrl_change, [1] penable_early, [2] addr_range, [3] abort.
- viol_cnt  out  8  saturating count of errored or aborted transfers.

Behaviour:
- Reset is synchronous, active-high, on PCLK. While PRESET=1 the block drives:
  - state=IDLE and the wait counter to 0;
  - PREADY=0, PSLVERR=0, PRDATA=0;
  - viol_status=0, viol_cnt=0;
  - every memory word to 0.
- Reset asserted mid-transfer abandons the transfer with no write and no error recorded.
- FSM IDLE:
  - PSEL=0: stay in IDLE.
  - PSEL=1: go to SETUP and capture PADDR, PWRITE and PWDATA into the captured registers.
  - PSEL=1 with PENABLE=1 on the same cycle sets the penable_early flag for that transfer.
- FSM SETUP (one cycle):
  - Always go to ACCESS next.
  - Wait counter loads 0.
- FSM ACCESS:
  - PREADY is combinational: PREADY = (state==ACCESS) && (wait_cnt==WAIT_STATES).
  - wait_cnt increments each ACCESS cycle while PREADY=0.
  - WAIT_STATES=0 gives the minimum 2-cycle transfer.
- Control-change check: every ACCESS cycle, compare live inputs against the captured values.
  - Mismatch on PADDR or PWRITE sets the transfer's ctrl_change flag.
  - Mismatch on PWDATA sets it only when the captured PWRITE=1.
  - PENABLE=0 in ACCESS also sets ctrl_change.
- Completion cycle (PREADY=1):
  - err = ctrl_change | penable_early | (captured addr >= DEPTH).
  - PSLVERR = err.
  - Write: mem[addr] <= captured PWDATA on the clock edge, only if err=0.
  - Read: PRDATA = mem[addr] when err=0; otherwise PRDATA=0.
  - PRDATA=0 whenever PREADY=0.
- After completion: PSEL=1 goes to SETUP (back-to-back; capture anew, same penable_early rule); PSEL=0 goes to IDLE.
- Abort: PSEL=0 in ACCESS before PREADY=1.
  - Go to IDLE, perform no write, and set the abort flag.
  - The other per-transfer flags are still folded into viol_status.
- Status update on completion or abort:
  - viol_status |= transfer flags (addr_range is set when addr >= DEPTH).
  - viol_cnt increments by 1 if err or abort, saturating at 255.
  - Per-transfer flags clear on entering SETUP.
- A write to the same address immediately followed by a read returns the new data; there is no read-during-write hazard across transfers.

Decomposition:
- apb_pkg holds:
  - typedef enum {IDLE, SETUP, ACCESS} apb_state_e;
  - localparams VIOL_CTRL=0, VIOL_PEN=1, VIOL_ADDR=2, VIOL_ABORT=3;
  - a viol_flags_t packed struct.
- One sub-module, apb_viol_checker:
  - inputs: captured and live control signals, state, PREADY, PSEL;
  - output: per-transfer flags.
  - The FSM, memory and counters stay in apb_slave_mem.

Test Plan:
1. WAIT_STATES=0: write addr 5 = 0xA5A5_0001, then read addr 5 → write PREADY on the 2nd cycle with PSLVERR=0; read returns 0xA5A5_0001 with PSLVERR=0; viol_cnt=0.
2. WAIT_STATES=3: read addr 5 → PREADY low for 3 ACCESS cycles and high on the 4th; 5-cycle transfer; correct PRDATA.
3. PWRITE violation: SETUP with PWRITE=1, addr 7, data 0x1234; PWRITE driven to 0 in ACCESS → PSLVERR=1 at completion; mem[7] stays 0; viol_status=4'b0001; viol_cnt=1.
4. Address range: write addr 64 (DEPTH=64) → PSLVERR=1, no write, viol_status[2]=1. Then read addr 63 → PSLVERR=0.
5. Abort: WAIT_STATES=2 write to addr 3; PSEL dropped in the 1st ACCESS cycle → state IDLE, mem[3]=0, viol_status[3]=1, viol_cnt increments.
6. Early PENABLE plus reset: PSEL and PENABLE rise together → PSLVERR=1 and viol_status[1]=1. Then PRESET=1 for one cycle mid-ACCESS of the next write → outputs and status return to 0 and the next legal transfer succeeds. Additionally, 260 errored transfers → viol_cnt=255.
